// File: rtl/nco_voice_scheduler.sv
// Four time-multiplexed NCO voices sharing one quarter-wave table, mixed once per audio frame.
// Define NCO_VOICE_SCHEDULER_SAT_EN to clamp the mix; otherwise the mix is scaled down by 4.
module nco_voice_scheduler #(
    parameter int unsigned BITSIZE = 24,
    parameter int unsigned PHASE   = 16,
    parameter int unsigned TABLE   = 9,
    parameter int unsigned VOICES  = 4
) (
    input  logic               clk,
    input  logic               DACLRC,
    input  logic               strobe,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_voice,
    input  logic [PHASE-1:0]   cfg_step,
    input  logic [VOICES-1:0]  voice_en,
    output logic [TABLE-1:0]   rom_addr,
    input  logic [BITSIZE-1:0] rom_data,
    output logic [BITSIZE-1:0] sample_out,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int unsigned ACCW = BITSIZE + 2;
    localparam int unsigned VW   = $clog2(VOICES);

    localparam logic signed [ACCW-1:0] SatMax = {{3{1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SatMin = {{3{1'b1}}, {(BITSIZE-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StAddr, StWait, StAcc, StDone} state_e;

    state_e                   state_q, state_d;
    logic [VW-1:0]            voice_q, voice_d;
    logic signed [ACCW-1:0]   acc_q, acc_d;
    logic [PHASE-1:0]         phase_q  [VOICES];
    logic [PHASE-1:0]         step_q   [VOICES];
    logic [PHASE-1:0]         shadow_q [VOICES];
    logic [VOICES-1:0]        en_q;
    logic                     sign_q;
    logic [TABLE-1:0]         rom_addr_q, rom_addr_d;
    logic [BITSIZE-1:0]       sample_q, sample_d;
    logic                     overrun_q;

    logic                     accept, phase_we, sample_we;
    logic [PHASE-1:0]         sel_phase;
    logic [TABLE-1:0]         sel_idx;
    logic signed [ACCW-1:0]   rom_ext, contrib, sample_sel;

    always_comb begin
        state_d   = state_q;
        voice_d   = voice_q;
        acc_d     = acc_q;
        accept    = 1'b0;
        phase_we  = 1'b0;
        sample_we = 1'b0;
        contrib   = '0;
        rom_ext   = {{2{rom_data[BITSIZE-1]}}, rom_data};
        unique case (state_q)
            StIdle: begin
                if (strobe) begin
                    accept  = 1'b1;
                    state_d = StAddr;
                    voice_d = '0;
                    acc_d   = '0;
                end
            end
            StAddr: state_d = StWait;
            StWait: state_d = StAcc;
            StAcc: begin
                if (en_q[voice_q]) begin
                    contrib  = sign_q ? -rom_ext : rom_ext;
                    phase_we = 1'b1;
                end
                acc_d = acc_q + contrib;
                if (voice_q == VW'(VOICES - 1)) begin
                    state_d   = StDone;
                    sample_we = 1'b1;
                end else begin
                    state_d = StAddr;
                    voice_d = voice_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Table lookup is folded on the quarter bit; the sign bit is applied at accumulate time.
    always_comb begin
        sel_phase  = phase_q[voice_d];
        sel_idx    = sel_phase[PHASE-3 -: TABLE];
        rom_addr_d = sel_phase[PHASE-2] ? ~sel_idx : sel_idx;
    end

    always_comb begin
`ifdef NCO_VOICE_SCHEDULER_SAT_EN
        if (acc_d > SatMax) begin
            sample_sel = SatMax;
        end else if (acc_d < SatMin) begin
            sample_sel = SatMin;
        end else begin
            sample_sel = acc_d;
        end
`else
        sample_sel = acc_d >>> 2;
`endif
        sample_d = sample_sel[BITSIZE-1:0];
    end

    always_ff @(posedge clk or posedge DACLRC) begin
        if (DACLRC) begin
            state_q    <= StIdle;
            voice_q    <= '0;
            acc_q      <= '0;
            en_q       <= '0;
            sign_q     <= 1'b0;
            rom_addr_q <= '0;
            sample_q   <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                phase_q[i]  <= '0;
                step_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            voice_q   <= voice_d;
            acc_q     <= acc_d;
            overrun_q <= strobe && (state_q != StIdle);
            if (cfg_we) begin
                step_q[cfg_voice] <= cfg_step;
            end
            if (accept) begin
                shadow_q <= step_q;
                en_q     <= voice_en;
            end
            if (state_d == StAddr) begin
                rom_addr_q <= rom_addr_d;
                sign_q     <= sel_phase[PHASE-1];
            end
            if (phase_we) begin
                phase_q[voice_q] <= phase_q[voice_q] + shadow_q[voice_q];
            end
            if (sample_we) begin
                sample_q <= sample_d;
            end
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample_out   = sample_q;
    assign sample_valid = (state_q == StDone);
    assign busy         = (state_q != StIdle);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_nco_voice_scheduler.sv
// Randomized bench for nco_voice_scheduler against a frame-level arithmetic model of the mixer.
module tb_nco_voice_scheduler;

    logic        clk = 1'b0;
    logic        DACLRC;
    logic        strobe;
    logic        cfg_we;
    logic [1:0]  cfg_voice;
    logic [15:0] cfg_step;
    logic [3:0]  voice_en;
    logic [8:0]  rom_addr;
    logic [23:0] rom_data;
    logic [23:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] rom_mem [512];
    int unsigned m_phase [4];
    int unsigned m_step  [4];

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

    nco_voice_scheduler dut (
        .clk          (clk),
        .DACLRC       (DACLRC),
        .strobe       (strobe),
        .cfg_we       (cfg_we),
        .cfg_voice    (cfg_voice),
        .cfg_step     (cfg_step),
        .voice_en     (voice_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned fold_addr(input int unsigned p);
        int unsigned idx;
        idx = (p >> 5) % 512;
        return (((p >> 14) & 1) != 0) ? (511 - idx) : idx;
    endfunction

    function automatic logic [23:0] expected_sample(input longint sum);
        longint r;
`ifdef NCO_VOICE_SCHEDULER_SAT_EN
        if (sum > 8388607) r = 8388607;
        else if (sum < -8388608) r = -8388608;
        else r = sum;
`else
        r = sum >>> 2;
`endif
        return r[23:0];
    endfunction

    task automatic fill_rom(input int mode);
        for (int i = 0; i < 512; i++) begin
            case (mode)
                0:       rom_mem[i] = 24'($urandom_range(0, 24'h7FFFFF));
                1:       rom_mem[i] = 24'(i * 16);
                default: rom_mem[i] = 24'h7FFFFF;
            endcase
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_sample_out"}, 32'(sample_out), 32'd0);
        check_eq({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
        check_eq({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    task automatic do_reset();
        #2;
        DACLRC = 1'b1;
        #1;
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        DACLRC = 1'b0;
        for (int v = 0; v < 4; v++) begin
            m_phase[v] = 0;
            m_step[v]  = 0;
        end
    endtask

    task automatic set_step(input int v, input logic [15:0] s);
        cfg_we    = 1'b1;
        cfg_voice = 2'(v);
        cfg_step  = s;
        @(posedge clk);
        #1;
        cfg_we    = 1'b0;
        m_step[v] = s;
    endtask

    // Runs one frame from IDLE; optionally injects a second strobe or a step write mid-frame.
    task automatic run_frame(input logic [3:0] en, input int extra_at, input int cfg_at,
                             input logic [1:0] cfg_v, input logic [15:0] cfg_s);
        int unsigned addr [4];
        longint      sum;
        logic [23:0] exp_sample;
        int          n_ovr;
        sum = 0;
        for (int v = 0; v < 4; v++) begin
            addr[v] = fold_addr(m_phase[v]);
            if (en[v]) begin
                if (((m_phase[v] >> 15) & 1) != 0) sum -= longint'(rom_mem[addr[v]]);
                else sum += longint'(rom_mem[addr[v]]);
                m_phase[v] = (m_phase[v] + m_step[v]) % 65536;
            end
        end
        exp_sample = expected_sample(sum);
        n_ovr = 0;
        voice_en = en;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 1 || k == 4 || k == 7 || k == 10)
                check_eq("rom_addr", 32'(rom_addr), 32'(addr[(k - 1) / 3]));
            check_eq("busy", 32'(busy), 32'(k <= 13));
            check_eq("sample_valid", 32'(sample_valid), 32'(k == 13));
            if (k == 13 || k == 16) check_eq("sample_out", 32'(sample_out), 32'(exp_sample));
            if (overrun) n_ovr++;
            if (k == extra_at) strobe = 1'b1;
            if (k == cfg_at) begin
                cfg_we    = 1'b1;
                cfg_voice = cfg_v;
                cfg_step  = cfg_s;
            end
            @(posedge clk);
            #1;
            strobe = 1'b0;
            cfg_we = 1'b0;
            if (k == cfg_at) m_step[cfg_v] = cfg_s;
        end
        check_eq("overrun_pulses", 32'(n_ovr), 32'(extra_at != 0));
    endtask

    task automatic reset_mid_frame();
        voice_en = 4'hF;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("pre_reset_busy", 32'(busy), 32'd1);
        do_reset();
        for (int k = 0; k < 20; k++) begin
            check_eq("post_reset_valid", 32'(sample_valid), 32'd0);
            check_eq("post_reset_busy", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        DACLRC    = 1'b1;
        strobe    = 1'b0;
        cfg_we    = 1'b0;
        cfg_voice = '0;
        cfg_step  = '0;
        voice_en  = '0;
        fill_rom(0);
        #1;
        check_idle_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        DACLRC = 1'b0;
        for (int v = 0; v < 4; v++) begin
            m_phase[v] = 0;
            m_step[v]  = 0;
        end
        @(posedge clk);
        #1;

        // Linear table, single voice stepping 683: addresses 0 then 21.
        fill_rom(1);
        set_step(0, 16'd683);
        run_frame(4'b0001, 0, 0, 2'd0, 16'd0);
        run_frame(4'b0001, 0, 0, 2'd0, 16'd0);

        // Half-cycle step: sign alternates, phase wraps back to 0.
        do_reset();
        fill_rom(0);
        rom_mem[0] = 24'h123456;
        set_step(0, 16'h8000);
        repeat (3) run_frame(4'b0001, 0, 0, 2'd0, 16'd0);

        // Quarter step: second frame folds to address 511.
        do_reset();
        set_step(0, 16'h4000);
        repeat (2) run_frame(4'b0001, 0, 0, 2'd0, 16'd0);

        // Strobes while busy, including one coincident with DONE.
        run_frame(4'b0001, 5, 0, 2'd0, 16'd0);
        run_frame(4'b0011, 13, 0, 2'd0, 16'd0);

        // Full-scale table with all voices: positive then negative extremes.
        do_reset();
        fill_rom(2);
        for (int v = 0; v < 4; v++) set_step(v, 16'h4000);
        repeat (3) run_frame(4'b1111, 0, 0, 2'd0, 16'd0);

        // Reset in the middle of a frame, then a normal frame from zero phase.
        fill_rom(0);
        for (int v = 0; v < 4; v++) set_step(v, 16'($urandom));
        reset_mid_frame();
        for (int v = 0; v < 4; v++) set_step(v, 16'($urandom));
        run_frame(4'b1111, 0, 0, 2'd0, 16'd0);

        for (int f = 0; f < 40; f++) begin
            int ex;
            int ca;
            if (f % 10 == 0) fill_rom(0);
            ex = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 13)) : 0;
            ca = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : 0;
            run_frame(4'($urandom), ex, ca, 2'($urandom), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nco_voice_scheduler.md
NCO_VOICE_SCHEDULER -- requirements
Module: nco_voice_scheduler

Interface
REQ-001 SHALL have parameters: BITSIZE, 24, sample width; PHASE, 16, phase accumulator width; TABLE, 9, quarter-table address width; VOICES, 4, voice count (fixed at 4 in this version).
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have ports: DACLRC  in  1  reset DACLRC, asynchronous, active-high.
REQ-004 SHALL have ports: strobe  in  1  one-cycle frame-start pulse, once per audio frame.
REQ-005 SHALL have ports: cfg_we  in  1  step write; cfg_voice  in  2  target voice; cfg_step  in  PHASE  phase increment.
REQ-006 SHALL have ports: voice_en  in  VOICES  per-voice enable, sampled on accepted strobe.
REQ-007 SHALL have ports: rom_addr  out  TABLE  quarter-table address; rom_data  in  BITSIZE  table word, valid one clk after rom_addr.
REQ-008 SHALL have ports: sample_out  out  BITSIZE  mixed signed sample; sample_valid  out  1  one-cycle pulse; busy  out  1  frame in progress; overrun  out  1  one-cycle pulse.

Function
REQ-009 SHALL hold per-voice phase registers (PHASE bits) and step registers (PHASE bits); cfg_we writes step[cfg_voice] in the same cycle.
REQ-010 SHALL latch all steps into shadow registers and voice_en on the accepted strobe; cfg writes during a frame affect the next frame only.
REQ-011 FSM states: IDLE, ADDR, WAIT, ACC, DONE; IDLE->ADDR on strobe; per voice ADDR->WAIT->ACC; ACC->ADDR (next voice) or ->DONE after voice 3; DONE->IDLE.
REQ-012 In ADDR: rom_addr = ~phase[13:5] if phase[14] else phase[13:5]; capture sign = phase[15].
REQ-013 In ACC: enabled voice adds rom_data if sign=0, else two's-complement -rom_data, into a BITSIZE+2 signed accumulator; disabled voice adds 0.
REQ-014 In ACC: enabled voice phase <= phase + shadow step, modulo 2^PHASE (wrap silently); disabled voice phase holds.
REQ-015 Lookup uses the phase value before that frame's increment.
REQ-016 Accumulator cleared on accepted strobe.
REQ-017 sample_valid SHALL pulse exactly 13 clk (3*VOICES+1) after the cycle strobe is sampled high; sample_out updates in that cycle and holds until next DONE.
REQ-018 busy high from cycle after accepted strobe through DONE inclusive.
REQ-019 strobe while busy SHALL be ignored and pulse overrun one clk; current frame unaffected.
REQ-020 strobe coincident with DONE is ignored with overrun; strobe in IDLE accepted.
REQ-021 Voice processing order fixed 0,1,2,3.
REQ-022 step = 0 with voice enabled: phase holds, voice still contributes its table value.

Reset
REQ-023 DACLRC high: FSM to IDLE, all phases/steps/shadows/accumulator to 0; sample_out 0, sample_valid 0, busy 0, overrun 0, rom_addr 0, asynchronously.
REQ-024 Reset mid-frame SHALL abort the frame; no sample_valid for it.
REQ-025 First strobe after reset release processed normally.

Configuration
REQ-026 Macro NCO_VOICE_SCHEDULER_SAT_EN: defined -> sample_out = accumulator clamped to [-2^23, 2^23-1].
REQ-027 Undefined -> sample_out = accumulator arithmetic-shifted right by 2 (truncated to BITSIZE); no clamp logic.

Verification
REQ-028 DACLRC pulse mid-frame (cycle 6) -> all outputs 0 immediately, no sample_valid, phases 0.
REQ-029 voice_en=0001, step0=683, ROM model rom[i]=i*16 -> frame1 rom_addr 0; frame2 rom_addr 21 (683>>5); sample_valid at strobe+13.
REQ-030 voice_en=0001, step0=0x8000 -> frames alternate +rom[0], -rom[0]; phase returns to 0 on frame 3 (wrap).
REQ-031 voice0 phase 0x4000 (step0=0x4000, second frame) -> rom_addr 511 (fold).
REQ-032 strobes 5 clk apart -> second ignored, overrun one pulse, single sample_valid at first strobe+13.
REQ-033 voice_en=1111, all steps 0x4000, second frame, ROM returns 0x7FFFFF -> SAT_EN: 0x7FFFFF; without: 0x7FFFFF (0x1FFFFFC>>>2).
